// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared constants for the data-memory responder: funct3 access-type
//   encodings, FSM state type and parameter defaults.
package dmem_responder_pkg;

    // funct3 access-type encodings (loads use all five, stores B/H/W only)
    localparam logic [2:0] BT_B  = 3'b000;
    localparam logic [2:0] BT_H  = 3'b001;
    localparam logic [2:0] BT_W  = 3'b010;
    localparam logic [2:0] BT_BU = 3'b100;
    localparam logic [2:0] BT_HU = 3'b101;

    localparam int MEM_ADDR_WIDTH_DEFAULT = 10;
    localparam int WORD_WIDTH_DEFAULT     = 32;
    localparam int LATENCY_DEFAULT        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if
//   Request/response bus between the MEM stage (master) and the data-memory
//   responder (slave).
//   Handshake: a request transfers on the rising edge where req_valid and
//   req_ready are both 1; a response retires on the rising edge where
//   rsp_valid and rsp_ready are both 1. A producer holds valid and its
//   payload stable until the transfer; ready may be asserted at any time
//   and has no effect while the matching valid is low.
//   Signals:
//     req_valid/req_ready  request handshake
//     req_wen              1 = store, 0 = load
//     req_addr             byte address
//     req_wdata            store data, right-justified
//     req_byt_typ          funct3 access type
//     rsp_valid/rsp_ready  response handshake
//     rsp_rdata            extended load data (0 for stores and errors)
//     rsp_err              misaligned access or illegal access type
interface dmem_responder_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_byt_typ;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_byt_typ, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_byt_typ, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_lane_fmt.sv
// dmem_lane_fmt
//   Combinational lane logic for one 32-bit RAM word.
//   Ports:
//     addr_lo  in   byte offset within the word
//     byt_typ  in   funct3 access type
//     wen      in   1 = store
//     wdata    in   right-justified store data
//     rword    in   current RAM word
//     rdata    out  extracted/extended load data, 0 for stores and errors
//     wword    out  RAM word with store lanes merged in
//     we_ok    out  store is legal and aligned; safe to write wword
//     err      out  misaligned or illegal access type
module dmem_lane_fmt
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  byt_typ,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] rdata,
    output logic [31:0] wword,
    output logic        we_ok,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_val;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        lane_b     = rword[{addr_lo, 3'b000} +: 8];
        lane_h     = rword[{addr_lo[1], 4'b0000} +: 16];
        ld_val     = '0;
        wword      = rword;
        illegal    = 1'b0;
        misaligned = 1'b0;

        case (byt_typ)
            BT_B: begin
                ld_val = {{24{lane_b[7]}}, lane_b};
                wword[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            BT_H: begin
                misaligned = addr_lo[0];
                ld_val = {{16{lane_h[15]}}, lane_h};
                wword[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            BT_W: begin
                misaligned = |addr_lo;
                ld_val = rword;
                wword  = wdata;
            end
            BT_BU: begin
                illegal = wen;          // unsigned variants exist for loads only
                ld_val  = {24'd0, lane_b};
            end
            BT_HU: begin
                illegal    = wen;
                misaligned = addr_lo[0];
                ld_val     = {16'd0, lane_h};
            end
            default: illegal = 1'b1;
        endcase

        err   = illegal | misaligned;
        we_ok = wen & ~err;
        rdata = (err | wen) ? 32'd0 : ld_val;
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder behind the MEM stage. Accepts one load/store at a
//   time, commits stores and reads load data on the acceptance edge, then
//   presents the response after LATENCY cycles (legal range 1..15).
//   rsp_valid is registered LATENCY-1 edges after the acceptance edge, so
//   the LATENCY-th rising edge after acceptance is the first to sample it.
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     bus        slave side of dmem_responder_if
//     dbg_state  out  current FSM state
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEFAULT,
    parameter int WORD_WIDTH     = WORD_WIDTH_DEFAULT,
    parameter int LATENCY        = LATENCY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output state_t           dbg_state
);

    localparam int         DEPTH    = 2 ** (MEM_ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    // RAM contents are deliberately not reset
    logic [WORD_WIDTH-1:0] ram [DEPTH];

    state_t                  state;
    logic [3:0]              cnt;
    logic                    rsp_valid_q;
    logic [WORD_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic [MEM_ADDR_WIDTH-3:0] word_idx;
    logic [WORD_WIDTH-1:0]     rword;
    logic [WORD_WIDTH-1:0]     fmt_rdata;
    logic [WORD_WIDTH-1:0]     fmt_wword;
    logic                      fmt_we_ok;
    logic                      fmt_err;
    logic                      accept;

    assign word_idx = bus.req_addr[MEM_ADDR_WIDTH-1:2];
    assign rword    = ram[word_idx];

    assign bus.req_ready = (state == ST_IDLE);
    assign accept        = bus.req_valid && (state == ST_IDLE);

    dmem_lane_fmt u_lane_fmt (
        .addr_lo (bus.req_addr[1:0]),
        .byt_typ (bus.req_byt_typ),
        .wen     (bus.req_wen),
        .wdata   (bus.req_wdata),
        .rword   (rword),
        .rdata   (fmt_rdata),
        .wword   (fmt_wword),
        .we_ok   (fmt_we_ok),
        .err     (fmt_err)
    );

    // Store commits on the acceptance edge; a later reset does not undo it.
    always_ff @(posedge clk) begin
        if (accept && fmt_we_ok) begin
            ram[word_idx] <= fmt_wword;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        // load data is captured now, before any later store
                        rsp_rdata_q <= fmt_rdata;
                        rsp_err_q   <= fmt_err;
                        if (LATENCY == 1) begin
                            state       <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        cnt         <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state;

endmodule
